// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: write/read sequencer for the three line RAMs behind the 3x3
// window of the edge-detection pipeline. It tracks column and line position,
// writes each incoming line into a rotating bank, and produces row selects
// that line up with the 1-cycle read latency of the RAMs.
module line_buf_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int AW       = 10,
    parameter int LW       = 10
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          sof,
    input  logic          pix_valid,
    output logic          wr_en_a,
    output logic          wr_en_b,
    output logic          wr_en_c,
    output logic [AW-1:0] ram_addr,
    output logic [1:0]    sel_row1,
    output logic [1:0]    sel_row2,
    output logic [1:0]    sel_row3,
    output logic          row_end,
    output logic          win_valid,
    output logic [LW-1:0] line_cnt,
    output logic          frame_done
);

    // Bank codes double as the row-mux select encoding (0 = idle).
    localparam logic [1:0] SEL_IDLE = 2'd0;
    localparam logic [1:0] BANK_A   = 2'd1;
    localparam logic [1:0] BANK_B   = 2'd2;
    localparam logic [1:0] BANK_C   = 2'd3;

    localparam logic [AW-1:0] COL_LAST  = AW'(H_ACTIVE - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(V_ACTIVE - 1);

    logic [AW-1:0] col;
    logic [1:0]    wr_bank;
    logic [1:0]    lines_stored;

    // State as seen by this cycle's pixel: sof restarts the frame first.
    logic [AW-1:0] col_eff;
    logic [1:0]    bank_eff;
    logic [1:0]    stored_eff;
    logic [LW-1:0] line_eff;
    logic          line_end;
    logic          frame_end;
    logic [1:0]    sel1_next;
    logic [1:0]    sel2_next;
    logic [1:0]    sel3_next;

    // Rotation order A -> B -> C -> A.
    function automatic logic [1:0] next_bank(input logic [1:0] b);
        case (b)
            BANK_A:  next_bank = BANK_B;
            BANK_B:  next_bank = BANK_C;
            default: next_bank = BANK_A;
        endcase
    endfunction

    // Effective position, line/frame end detection and window selects.
    always_comb begin
        col_eff    = sof ? '0 : col;
        bank_eff   = sof ? BANK_A : wr_bank;
        stored_eff = sof ? 2'd0 : lines_stored;
        line_eff   = sof ? '0 : line_cnt;

        line_end  = pix_valid && (col_eff == COL_LAST);
        frame_end = line_end && (line_eff == LINE_LAST);

        // Read-before-write: the bank being written still holds line n-3.
        sel1_next = (stored_eff == 2'd3) ? bank_eff : SEL_IDLE;
        sel2_next = (stored_eff >= 2'd2) ? next_bank(bank_eff) : SEL_IDLE;
        sel3_next = (stored_eff >= 2'd1) ? next_bank(next_bank(bank_eff)) : SEL_IDLE;
    end

    // RAM write strobes and shared column address.
    // NOTE: the strobes are combinational from registered state, so they are
    // also gated by aclr to stay low for the whole reset, not just after it.
    assign wr_en_a  = aclr && pix_valid && (bank_eff == BANK_A);
    assign wr_en_b  = aclr && pix_valid && (bank_eff == BANK_B);
    assign wr_en_c  = aclr && pix_valid && (bank_eff == BANK_C);
    assign ram_addr = col_eff;

    // Position counters, bank rotation and the read-aligned output registers.
    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            col          <= '0;
            wr_bank      <= BANK_A;
            lines_stored <= 2'd0;
            line_cnt     <= '0;
            sel_row1     <= SEL_IDLE;
            sel_row2     <= SEL_IDLE;
            sel_row3     <= SEL_IDLE;
            row_end      <= 1'b0;
            win_valid    <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            row_end    <= line_end;
            win_valid  <= pix_valid && (stored_eff == 2'd3);
            frame_done <= frame_end;

            // NOTE: defaults first, pixel updates below override them; with
            // non-blocking assignments the last one in program order wins.
            col          <= col_eff;
            wr_bank      <= bank_eff;
            lines_stored <= stored_eff;
            line_cnt     <= line_eff;

            if (pix_valid) begin
                sel_row1 <= sel1_next;
                sel_row2 <= sel2_next;
                sel_row3 <= sel3_next;
                if (line_end) begin
                    col          <= '0;
                    wr_bank      <= next_bank(bank_eff);
                    lines_stored <= (stored_eff == 2'd3) ? 2'd3 : stored_eff + 2'd1;
                    line_cnt     <= frame_end ? '0 : line_eff + 1'b1;
                end else begin
                    col <= col_eff + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Directed bench for line_buf_ctrl with an 8x4 frame: bank rotation, window
// selects, gaps in pix_valid, frame wrap, mid-line sof and async reset.
module tb_line_buf_ctrl;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int AW = 10;
    localparam int LW = 10;

    logic          clk;
    logic          aclr;
    logic          sof;
    logic          pix_valid;
    logic          wr_en_a, wr_en_b, wr_en_c;
    logic [AW-1:0] ram_addr;
    logic [1:0]    sel_row1, sel_row2, sel_row3;
    logic          row_end, win_valid, frame_done;
    logic [LW-1:0] line_cnt;

    int checks = 0;
    int errors = 0;
    logic [5:0] last_sel;

    line_buf_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .AW(AW), .LW(LW)) dut (
        .clk        (clk),
        .aclr       (aclr),
        .sof        (sof),
        .pix_valid  (pix_valid),
        .wr_en_a    (wr_en_a),
        .wr_en_b    (wr_en_b),
        .wr_en_c    (wr_en_c),
        .ram_addr   (ram_addr),
        .sel_row1   (sel_row1),
        .sel_row2   (sel_row2),
        .sel_row3   (sel_row3),
        .row_end    (row_end),
        .win_valid  (win_valid),
        .line_cnt   (line_cnt),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle (called at posedge+1), check the write side mid-cycle,
    // then return at the next posedge+1 with the registered side updated.
    task automatic pix(input logic v, input logic s, input logic [2:0] exp_wen, input int exp_addr);
        pix_valid = v;
        sof       = s;
        #1;
        check("wr_en", {29'd0, wr_en_c, wr_en_b, wr_en_a}, {29'd0, exp_wen});
        if (v) check("ram_addr", 32'(ram_addr), 32'(exp_addr));
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic check_regs(input string tag, input logic [5:0] sel, input logic re,
                              input logic wv, input logic fd);
        check({tag, "_sel"}, {26'd0, sel_row1, sel_row2, sel_row3}, {26'd0, sel});
        check({tag, "_row_end"}, {31'd0, row_end}, {31'd0, re});
        check({tag, "_win_valid"}, {31'd0, win_valid}, {31'd0, wv});
        check({tag, "_frame_done"}, {31'd0, frame_done}, {31'd0, fd});
    endtask

    // One line from column first_col to H-1; optional 2 blank cycles before
    // each pixel. fd marks the last line of the frame.
    task automatic run_line(input int idx, input int first_col, input logic [2:0] wen,
                            input logic [5:0] sel, input logic wv, input bit gap, input bit fd);
        check("line_cnt_start", 32'(line_cnt), 32'(idx));
        for (int c = first_col; c < H; c++) begin
            if (gap) begin
                for (int g = 0; g < 2; g++) begin
                    pix(1'b0, 1'b0, 3'b000, 0);
                    check_regs("gap", last_sel, 1'b0, 1'b0, 1'b0);
                end
            end
            pix(1'b1, 1'b0, wen, c);
            check_regs("pix", sel, c == H - 1, wv, fd && (c == H - 1));
            last_sel = sel;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        aclr      = 1'b0;
        sof       = 1'b0;
        pix_valid = 1'b1;
        last_sel  = 6'd0;
        #2;
        check("rst_wr_en", {29'd0, wr_en_c, wr_en_b, wr_en_a}, 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_line_cnt", 32'(line_cnt), 32'd0);
        check_regs("rst", 6'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        aclr      = 1'b1;

        // Lines 0..3 of frame: banks A, B, C, A; window fills up.
        run_line(0, 0, 3'b001, 6'b00_00_00, 1'b0, 1'b0, 1'b0);
        pix(1'b0, 1'b0, 3'b000, 0);
        check_regs("idle", 6'b00_00_00, 1'b0, 1'b0, 1'b0);
        run_line(1, 0, 3'b010, 6'b00_00_01, 1'b0, 1'b0, 1'b0);
        run_line(2, 0, 3'b100, 6'b00_01_10, 1'b0, 1'b0, 1'b0);
        run_line(3, 0, 3'b001, 6'b01_10_11, 1'b1, 1'b0, 1'b1);

        // Frame wrapped; rotation continues into bank B, with 1-of-3 duty.
        run_line(0, 0, 3'b010, 6'b10_11_01, 1'b1, 1'b1, 1'b0);
        check("line_cnt_after_gap_line", 32'(line_cnt), 32'd1);

        // Line 1 into bank C, aborted by sof at column 5.
        for (int c = 0; c < 5; c++) begin
            pix(1'b1, 1'b0, 3'b100, c);
            check_regs("pre_sof", 6'b11_01_10, 1'b0, 1'b1, 1'b0);
        end
        pix(1'b1, 1'b1, 3'b001, 0);
        check_regs("sof", 6'b00_00_00, 1'b0, 1'b0, 1'b0);
        last_sel = 6'd0;
        run_line(0, 1, 3'b001, 6'b00_00_00, 1'b0, 1'b0, 1'b0);

        // Line 1 into bank B, async reset at column 3.
        run_line(1, H, 3'b010, 6'b00_00_01, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            pix(1'b1, 1'b0, 3'b010, c);
            check_regs("pre_rst", 6'b00_00_01, 1'b0, 1'b0, 1'b0);
        end
        pix_valid = 1'b1;
        #1;
        check("pre_rst_wr_en", {29'd0, wr_en_c, wr_en_b, wr_en_a}, 32'b010);
        check("pre_rst_addr", 32'(ram_addr), 32'd3);
        aclr = 1'b0;
        #1;
        check("arst_wr_en", {29'd0, wr_en_c, wr_en_b, wr_en_a}, 32'd0);
        check("arst_addr", 32'(ram_addr), 32'd0);
        check("arst_line_cnt", 32'(line_cnt), 32'd0);
        check_regs("arst", 6'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        aclr      = 1'b1;
        pix(1'b1, 1'b0, 3'b001, 0);
        check_regs("post_rst", 6'd0, 1'b0, 1'b0, 1'b0);
        pix(1'b1, 1'b0, 3'b001, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/line_buf_ctrl.md
Name: line_buf_ctrl

Overview:
- Sequencer for the three-line-buffer 3x3 window datapath in the CCD edge-detection pipeline.
- Tracks pixel column and line position within a frame.
- Drives write enables and addresses for three line RAMs (banks A, B, C), rotating the write bank every line.
- Generates the sel_row1/2/3 bank selects and the row_end pulse consumed by the row mux, all aligned to 1-cycle synchronous RAM read latency.

Parameters:
- H_ACTIVE, 640, active pixels per line; must be ≤ 2^AW.
- V_ACTIVE, 480, active lines per frame.
- AW, 10, line RAM address width.
- LW, 10, line counter width; V_ACTIVE ≤ 2^LW.

Ports:
- clk  in  1  pixel clock.
- aclr  in  1  reset, asynchronous, active-low.
- sof  in  1  start-of-frame strobe, 1-cycle pulse.
- pix_valid  in  1  incoming pixel valid this cycle.
- wr_en_a  out  1  write enable, line RAM A.
- wr_en_b  out  1  write enable, line RAM B.
- wr_en_c  out  1  write enable, line RAM C.
- ram_addr  out  AW  shared read/write address for all three RAMs (column).
- sel_row1  out  2  bank select, window top row (oldest line).
- sel_row2  out  2  bank select, window middle row.
- sel_row3  out  2  bank select, window bottom row (newest stored line).
- row_end  out  1  pulse aligned with the last pixel of a line at RAM read data.
- win_valid  out  1  RAM read data this cycle forms a full 3-line column.
- line_cnt  out  LW  current line index within the frame.
- frame_done  out  1  1-cycle pulse after line V_ACTIVE-1 completes.

Behaviour:
- Select encoding: 0 = idle (mux outputs 0), 1 = A, 2 = B, 3 = C.
- State:
  - col counter 0..H_ACTIVE-1.
  - wr_bank in {A, B, C}.
  - lines_stored, saturating 0..3.
  - line_cnt 0..V_ACTIVE-1.
- RAM model: read-before-write. Reading an address being written returns the old contents.
- Combinational outputs, valid in the pix_valid cycle:
  - ram_addr = col.
  - wr_en_x = pix_valid & (wr_bank == x). Exactly one or zero enables high.
- On pix_valid with col < H_ACTIVE-1: col increments.
- On pix_valid with col == H_ACTIVE-1 (line end):
  - col → 0.
  - wr_bank rotates A→B→C→A.
  - lines_stored increments, saturating at 3.
  - line_cnt increments.
- Frame end:
  - If the line end is also line V_ACTIVE-1: line_cnt → 0 and frame_done pulses the next cycle.
  - wr_bank and lines_stored are unaffected by the frame end itself.
- Window mapping, for write bank W, next(W) as the rotation above:
  - sel_row1 = W (line n-3, from read-before-write).
  - sel_row2 = next(W) (line n-2).
  - sel_row3 = next(next(W)) (line n-1).
- Idle forcing of selects:
  - sel_row1 forced idle if lines_stored < 3.
  - sel_row2 forced idle if lines_stored < 2.
  - sel_row3 forced idle if lines_stored < 1.
- Registered outputs (1-cycle latency, to match RAM read data):
  - sel_row1/2/3 are registered from the values computed in the pix_valid cycle (pre-rotation).
  - If pix_valid = 0, the selects hold their previous values.
  - row_end = registered (pix_valid & col == H_ACTIVE-1).
  - win_valid = registered (pix_valid & lines_stored == 3).
- Blanking: while pix_valid = 0, all counters hold; wr_en_* = 0; row_end = 0; win_valid = 0.
- sof handling:
  - Synchronously: col → 0, line_cnt → 0, lines_stored → 0, wr_bank → A.
  - If pix_valid is high in the same cycle, that pixel is column 0 of the new frame: written to A at address 0, then col → 1.
  - sof has priority over any line-end or frame-end update in that cycle.
- sof mid-line: the partial line is discarded. No row_end or frame_done is generated for it.
- Reset (aclr low, any time):
  - All counters 0, wr_bank = A.
  - sel_row1/2/3 = 0, row_end = 0, win_valid = 0, frame_done = 0, line_cnt = 0.
  - wr_en_* = 0 while in reset.
- Reset release: the first pixel requires neither sof nor any warm-up cycle.

Test Plan:
- Reset then 1 line of H_ACTIVE=8 pixels:
  - wr_en_a high for 8 cycles, addresses 0..7.
  - All selects 0, win_valid 0.
  - row_end high exactly 1 cycle after the 8th pixel.
- 4 lines back to back, H_ACTIVE=8:
  - Write banks A, B, C, A.
  - During line 3 (bank A): registered sel_row1/2/3 = 1/2/3.
  - During line 2: sel = 0/1/2. During line 1: sel = 0/0/1.
  - win_valid first rises 1 cycle after line 3, pixel 0.
- pix_valid gaps (1-of-3 duty) inside a line:
  - col and addresses advance only on valid cycles.
  - Selects hold across gaps; no row_end until the 8th valid pixel.
- V_ACTIVE=4, 5 lines:
  - frame_done pulses once, 1 cycle after line 3 ends.
  - line_cnt wraps to 0; bank rotation continues (line 4 written to B).
- sof at col 5, with pix_valid high, mid-line 2:
  - That pixel is written to A at address 0.
  - lines_stored = 0, so selects return to 0/0/0.
  - No row_end or frame_done is generated for the aborted line.
- aclr asserted at col 3 of line 3:
  - All outputs 0 immediately, asynchronously.
  - After release, the first valid pixel writes bank A, address 0.
